dmem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the 256x16 synchronous data RAM in the processor datapath. It shares the RAM between the processor (CPU port, driven by the control unit's D_Addr/D_Wr path) and a host/debug port used for program-data loading and result readback. It serialises accesses with a registered grant, drives the RAM control signals, and returns read data with a one-cycle valid pulse.

---
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and access sequencer for the synchronous data RAM.
// Grants one access at a time (CPU / host), drives registered RAM controls, returns read data.
module dmem_arbiter #(
   parameter int unsigned ADDR_W       = 8,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned CPU_PRIORITY = 0
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StAccess, StRdata} state_e;

   localparam logic [1:0] OwnNone = 2'b00;
   localparam logic [1:0] OwnCpu  = 2'b01;
   localparam logic [1:0] OwnHost = 2'b10;

   state_e            state_q, state_d;
   logic              cpu_gnt_q, cpu_gnt_d;
   logic              host_gnt_q, host_gnt_d;
   logic              cpu_rvalid_q, cpu_rvalid_d;
   logic              host_rvalid_q, host_rvalid_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]        owner_q, owner_d;
   logic              last_host_q, last_host_d;
   logic              pick_cpu;

   // On a tie the CPU wins under fixed priority, or when the host had the previous grant.
   assign pick_cpu = cpu_req && (!host_req || (CPU_PRIORITY != 0) || last_host_q);

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q       <= StIdle;
         cpu_gnt_q     <= 1'b0;
         host_gnt_q    <= 1'b0;
         cpu_rvalid_q  <= 1'b0;
         host_rvalid_q <= 1'b0;
         cpu_rdata_q   <= '0;
         host_rdata_q  <= '0;
         mem_addr_q    <= '0;
         mem_we_q      <= 1'b0;
         mem_wdata_q   <= '0;
         owner_q       <= OwnNone;
         last_host_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         cpu_gnt_q     <= cpu_gnt_d;
         host_gnt_q    <= host_gnt_d;
         cpu_rvalid_q  <= cpu_rvalid_d;
         host_rvalid_q <= host_rvalid_d;
         cpu_rdata_q   <= cpu_rdata_d;
         host_rdata_q  <= host_rdata_d;
         mem_addr_q    <= mem_addr_d;
         mem_we_q      <= mem_we_d;
         mem_wdata_q   <= mem_wdata_d;
         owner_q       <= owner_d;
         last_host_q   <= last_host_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cpu_gnt_d     = 1'b0;
      host_gnt_d    = 1'b0;
      cpu_rvalid_d  = 1'b0;
      host_rvalid_d = 1'b0;
      cpu_rdata_d   = cpu_rdata_q;
      host_rdata_d  = host_rdata_q;
      mem_addr_d    = mem_addr_q;
      mem_we_d      = 1'b0;
      mem_wdata_d   = mem_wdata_q;
      owner_d       = owner_q;
      last_host_d   = last_host_q;

      unique case (state_q)
         StIdle: begin
            if (cpu_req || host_req) begin
               state_d = StAccess;
               if (pick_cpu) begin
                  mem_addr_d  = cpu_addr;
                  mem_we_d    = cpu_we;
                  mem_wdata_d = cpu_wdata;
                  cpu_gnt_d   = 1'b1;
                  owner_d     = OwnCpu;
                  last_host_d = 1'b0;
               end else begin
                  mem_addr_d  = host_addr;
                  mem_we_d    = host_we;
                  mem_wdata_d = host_wdata;
                  host_gnt_d  = 1'b1;
                  owner_d     = OwnHost;
                  last_host_d = 1'b1;
               end
            end
         end
         StAccess: begin
            // RAM samples the address at the end of this cycle; writes finish here.
            if (mem_we_q) begin
               state_d = StIdle;
               owner_d = OwnNone;
            end else begin
               state_d = StRdata;
            end
         end
         StRdata: begin
            if (owner_q == OwnCpu) begin
               cpu_rvalid_d = 1'b1;
               cpu_rdata_d  = mem_rdata;
            end else begin
               host_rvalid_d = 1'b1;
               host_rdata_d  = mem_rdata;
            end
            state_d = StIdle;
            owner_d = OwnNone;
         end
         default: begin
            state_d = StIdle;
            owner_d = OwnNone;
         end
      endcase
   end

   assign cpu_gnt     = cpu_gnt_q;
   assign host_gnt    = host_gnt_q;
   assign cpu_rvalid  = cpu_rvalid_q;
   assign host_rvalid = host_rvalid_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign host_rdata  = host_rdata_q;
   assign mem_addr    = mem_addr_q;
   assign mem_we      = mem_we_q;
   assign mem_wdata   = mem_wdata_q;
   assign owner       = owner_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin and fixed-priority instances share the
// same stimulus, each with its own synchronous RAM model.
module tb_dmem_arbiter;

   logic        clk;
   logic        Reset;
   logic        cpu_req, cpu_we, host_req, host_we;
   logic [7:0]  cpu_addr, host_addr;
   logic [15:0] cpu_wdata, host_wdata;

   logic        cpu_gnt0, cpu_rvalid0, host_gnt0, host_rvalid0, mem_we0, busy0;
   logic [15:0] cpu_rdata0, host_rdata0, mem_wdata0, mem_rdata0;
   logic [7:0]  mem_addr0;
   logic [1:0]  owner0;

   logic        cpu_gnt1, cpu_rvalid1, host_gnt1, host_rvalid1, mem_we1, busy1;
   logic [15:0] cpu_rdata1, host_rdata1, mem_wdata1, mem_rdata1;
   logic [7:0]  mem_addr1;
   logic [1:0]  owner1;

   logic [15:0] ram0 [256];
   logic [15:0] ram1 [256];

   int n_checks = 0;
   int n_pass   = 0;

   dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .CPU_PRIORITY(0)) dut0 (
      .clk(clk), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt0), .cpu_rvalid(cpu_rvalid0), .cpu_rdata(cpu_rdata0),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt0), .host_rvalid(host_rvalid0), .host_rdata(host_rdata0),
      .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
      .owner(owner0), .busy(busy0)
   );

   dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .CPU_PRIORITY(1)) dut1 (
      .clk(clk), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt1), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt1), .host_rvalid(host_rvalid1), .host_rdata(host_rdata1),
      .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
      .owner(owner1), .busy(busy1)
   );

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram0[i] = 16'hA500 | 16'(i);
         ram1[i] = 16'hA500 | 16'(i);
      end
   end

   // Synchronous RAMs: registered read of the address sampled at each edge.
   always @(posedge clk) begin
      mem_rdata0 <= ram0[mem_addr0];
      if (mem_we0) ram0[mem_addr0] = mem_wdata0;
   end

   always @(posedge clk) begin
      mem_rdata1 <= ram1[mem_addr1];
      if (mem_we1) ram1[mem_addr1] = mem_wdata1;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      Reset = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
      tick(); tick();
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_owner", 32'(owner0), 32'd0);
      check("rst_mem_we", 32'(mem_we0), 32'd0);
      check("rst_gnt", 32'({cpu_gnt0, host_gnt0}), 32'd0);
      check("rst_rdata", 32'(cpu_rdata0), 32'd0);
      Reset = 1'b1;
      tick();

      // CPU write 1A <= 1234
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h1A; cpu_wdata = 16'h1234;
      tick();
      cpu_req = 0;
      check("wr_gnt", 32'(cpu_gnt0), 32'd1);
      check("wr_mem_we", 32'(mem_we0), 32'd1);
      check("wr_mem_addr", 32'(mem_addr0), 32'h1A);
      check("wr_mem_wdata", 32'(mem_wdata0), 32'h1234);
      check("wr_owner", 32'(owner0), 32'd1);
      check("wr_busy", 32'(busy0), 32'd1);
      tick();
      check("wr_we_drop", 32'(mem_we0), 32'd0);
      check("wr_gnt_drop", 32'(cpu_gnt0), 32'd0);
      check("wr_idle", 32'({busy0, owner0}), 32'd0);
      check("wr_ram", 32'(ram0[8'h1A]), 32'h1234);

      // Host read-back of 1A
      host_req = 1; host_we = 0; host_addr = 8'h1A;
      tick();
      host_req = 0;
      check("hr_gnt", 32'(host_gnt0), 32'd1);
      check("hr_owner", 32'(owner0), 32'd2);
      check("hr_mem_we", 32'(mem_we0), 32'd0);
      tick();
      check("hr_rdata_busy", 32'(busy0), 32'd1);
      check("hr_early_rvalid", 32'(host_rvalid0), 32'd0);
      tick();
      check("hr_rvalid", 32'(host_rvalid0), 32'd1);
      check("hr_rdata", 32'(host_rdata0), 32'h1234);
      check("hr_cpu_rvalid", 32'(cpu_rvalid0), 32'd0);
      check("hr_done", 32'({busy0, owner0}), 32'd0);
      tick();
      check("hr_rvalid_clr", 32'(host_rvalid0), 32'd0);
      check("hr_rdata_hold", 32'(host_rdata0), 32'h1234);

      // Continuous tie from reset: dut0 alternates, dut1 always serves the CPU
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01;
      host_req = 1; host_we = 0; host_addr = 8'h02;
      tick();
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rr_cpu_gnt%0d", k), 32'(cpu_gnt0), 32'(k % 2 == 0));
         check($sformatf("rr_host_gnt%0d", k), 32'(host_gnt0), 32'(k % 2 == 1));
         check($sformatf("rr_addr%0d", k), 32'(mem_addr0), (k % 2 == 0) ? 32'h01 : 32'h02);
         check($sformatf("fp_gnt%0d", k), 32'({cpu_gnt1, host_gnt1}), 32'b10);
         tick(); tick();
         if (k % 2 == 0) begin
            check($sformatf("rr_cpu_rv%0d", k), 32'({cpu_rvalid0, cpu_rdata0}), 32'h1_A501);
         end else begin
            check($sformatf("rr_host_rv%0d", k), 32'({host_rvalid0, host_rdata0}), 32'h1_A502);
         end
         check($sformatf("fp_cpu_rv%0d", k), 32'({cpu_rvalid1, cpu_rdata1}), 32'h1_A501);
         if (k < 3) tick();
      end
      cpu_req = 0;
      tick();
      check("fp_host_after", 32'({cpu_gnt1, host_gnt1}), 32'b01);
      check("rr_host_alone", 32'({cpu_gnt0, host_gnt0}), 32'b01);
      host_req = 0;
      tick(); tick(); tick();

      // Reset during a CPU write ACCESS: mem_we drops at once and the RAM stays untouched
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 16'hBEEF;
      tick();
      cpu_req = 0;
      check("rw_mem_we", 32'(mem_we0), 32'd1);
      #2 Reset = 1'b0;
      #1;
      check("rw_async", 32'({mem_we0, cpu_gnt0, owner0, busy0}), 32'd0);
      tick();
      check("rw_ram_kept", 32'(ram0[8'h30]), 32'hA530);
      Reset = 1'b1;

      // Reset during a CPU read ACCESS: no rvalid ever follows
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
      tick();
      cpu_req = 0;
      check("rr_rd_gnt", 32'(cpu_gnt0), 32'd1);
      #2 Reset = 1'b0;
      #1;
      check("rr_rd_async", 32'({mem_we0, cpu_gnt0, owner0, busy0}), 32'd0);
      tick();
      Reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rr_no_rvalid%0d", k), 32'(cpu_rvalid0), 32'd0);
         tick();
      end
      host_req = 1; host_we = 0; host_addr = 8'h1A;
      tick();
      host_req = 0;
      check("post_rst_gnt", 32'({host_gnt0, owner0}), 32'b1_10);
      tick(); tick();
      check("post_rst_read", 32'({host_rvalid0, host_rdata0}), 32'h1_1234);

      // Back-to-back CPU writes two cycles apart
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 16'h0001;
      tick();
      check("b2b_first", 32'({cpu_gnt0, mem_we0, mem_addr0}), 32'h3_10);
      cpu_addr = 8'h11; cpu_wdata = 16'h0002;
      tick();
      check("b2b_gap", 32'({mem_we0, busy0}), 32'd0);
      tick();
      cpu_req = 0;
      check("b2b_second", 32'({cpu_gnt0, mem_we0, mem_addr0}), 32'h3_11);
      check("b2b_wdata", 32'(mem_wdata0), 32'h0002);
      tick();
      check("b2b_ram10", 32'(ram0[8'h10]), 32'h0001);
      check("b2b_ram11", 32'(ram0[8'h11]), 32'h0002);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
